uart_packet_controller: RTL

//  Parametrised packet layer between sensor core and byte-level UART (rs232 byte stream).
//  TX: queues variable-length packets (1..TX_MAX_BYTES) in a TX_DEPTH-entry FIFO, serialises MSB byte first.
//  RX: parses PC commands (0- or 1-argument), gates by core busy, aborts stalled commands on timeout.

---
 rtl/uart_packet_controller_if.sv | 43 ++++
 rtl/uart_packet_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_controller_if.sv
// rtl/uart_packet_controller_if.sv - packet/byte/command handshake bundle for uart_packet_controller
interface uart_packet_controller_if #(
  parameter int TX_MAX_BYTES = 5
);
  localparam int LEN_W = $clog2(TX_MAX_BYTES + 1);

  // Packet side (sensor core -> controller)
  logic [8*TX_MAX_BYTES-1:0] i_TX_DATA;
  logic [LEN_W-1:0]          i_TX_LEN;
  logic                      i_TX_VALID;
  logic                      o_TX_READY;
  logic                      o_TX_DROP;

  // Byte stream to the UART transmitter
  logic [7:0]                o_BYTE_TX;
  logic                      o_BYTE_TX_VALID;
  logic                      i_BYTE_TX_READY;

  // Byte stream from the UART receiver and parsed commands
  logic [7:0]                i_BYTE_RX;
  logic                      i_BYTE_RX_VALID;
  logic                      i_CORE_BUSY;
  logic [7:0]                o_RX_CMD;
  logic [7:0]                o_RX_ARG;
  logic                      o_RX_VALID;
  logic                      o_RX_ERR;

  // Controller side
  modport slave (
    input  i_TX_DATA, i_TX_LEN, i_TX_VALID, i_BYTE_TX_READY,
           i_BYTE_RX, i_BYTE_RX_VALID, i_CORE_BUSY,
    output o_TX_READY, o_TX_DROP, o_BYTE_TX, o_BYTE_TX_VALID,
           o_RX_CMD, o_RX_ARG, o_RX_VALID, o_RX_ERR
  );

  // Core/UART side driving the controller
  modport master (
    output i_TX_DATA, i_TX_LEN, i_TX_VALID, i_BYTE_TX_READY,
           i_BYTE_RX, i_BYTE_RX_VALID, i_CORE_BUSY,
    input  o_TX_READY, o_TX_DROP, o_BYTE_TX, o_BYTE_TX_VALID,
           o_RX_CMD, o_RX_ARG, o_RX_VALID, o_RX_ERR
  );
endinterface

// File: rtl/uart_packet_controller.sv
// rtl/uart_packet_controller.sv - packet FIFO/serialiser towards the UART and command parser from it
module uart_packet_controller #(
  parameter int TX_MAX_BYTES = 5,
  parameter int TX_DEPTH     = 4,
  parameter int RX_TIMEOUT   = 1000
) (
  input logic                     i_CLK,
  input logic                     i_RST,
  uart_packet_controller_if.slave bus
);

  localparam int LEN_W  = $clog2(TX_MAX_BYTES + 1);
  localparam int DATA_W = 8 * TX_MAX_BYTES;
  localparam int PTR_W  = $clog2(TX_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(RX_TIMEOUT);

  localparam logic [7:0] CMD_READ = 8'h52;  // 'R', no argument
  localparam logic [7:0] CMD_STOP = 8'h53;  // 'S', no argument, allowed while busy
  localparam logic [7:0] CMD_ADDR = 8'h61;  // 'a', one argument
  localparam logic [7:0] CMD_MODE = 8'h6D;  // 'm', one argument

  typedef enum logic {T_IDLE, T_SEND} tx_state_e;
  typedef enum logic {R_CMD, R_ARG}   rx_state_e;

  // ---------------------------------------------------------------- TX path
  logic [DATA_W-1:0] fifo_data_q [TX_DEPTH];
  logic [LEN_W-1:0]  fifo_len_q  [TX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              tx_drop_q, tx_drop_d;
  tx_state_e         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  logic tx_ready;
  logic tx_accept;
  logic len_ok;
  logic push;
  logic pop;
  logic byte_valid;

  // Ready is a function of the registered count only, so a pop on the same
  // edge never lets a push into a full FIFO.
  assign tx_ready  = (count_q != CNT_W'(TX_DEPTH));
  assign tx_accept = bus.i_TX_VALID & tx_ready;
  assign len_ok    = (bus.i_TX_LEN != '0) && (bus.i_TX_LEN <= LEN_W'(TX_MAX_BYTES));
  assign push      = tx_accept & len_ok;

  assign bus.o_TX_READY      = tx_ready;
  assign bus.o_TX_DROP       = tx_drop_q;
  assign bus.o_BYTE_TX_VALID = byte_valid;
  assign bus.o_BYTE_TX       = byte_valid ? shreg_q[DATA_W-1 -: 8] : 8'h00;

  // FIFO storage: written on accepted well-formed packets, contents need no reset.
  always_ff @(posedge i_CLK) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.i_TX_DATA;
      fifo_len_q[wr_ptr_q]  <= bus.i_TX_LEN;
    end
  end

  // TX next state: pop into the shift register when idle, shift out MSB byte first.
  always_comb begin
    tx_state_d = tx_state_q;
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    pop        = 1'b0;
    byte_valid = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          shreg_d    = fifo_data_q[rd_ptr_q];
          rem_d      = fifo_len_q[rd_ptr_q];
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        byte_valid = 1'b1;
        if (bus.i_BYTE_TX_READY) begin
          shreg_d = shreg_q << 8;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            tx_state_d = T_IDLE;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // FIFO bookkeeping and the bad-length drop pulse.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    tx_drop_d = tx_accept & ~len_ok;
  end

  // TX state register; reset discards queued and in-flight packets.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      tx_state_q <= T_IDLE;
      shreg_q    <= '0;
      rem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_drop_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      shreg_q    <= shreg_d;
      rem_q      <= rem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_drop_q  <= tx_drop_d;
    end
  end

  // ---------------------------------------------------------------- RX path
  rx_state_e        rx_state_q, rx_state_d;
  logic [7:0]       arg_cmd_q, arg_cmd_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       rx_cmd_q, rx_cmd_d;
  logic [7:0]       rx_arg_q, rx_arg_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;
  logic             rx_blocked;

  // While the core streams only STOP gets through; a 00h byte is line noise.
  assign rx_blocked = (bus.i_BYTE_RX == 8'h00) ||
                      (bus.i_CORE_BUSY && (bus.i_BYTE_RX != CMD_STOP));

  assign bus.o_RX_CMD   = rx_cmd_q;
  assign bus.o_RX_ARG   = rx_arg_q;
  assign bus.o_RX_VALID = rx_valid_q;
  assign bus.o_RX_ERR   = rx_err_q;

  // RX next state: decode command bytes, collect the argument or time out.
  always_comb begin
    rx_state_d = rx_state_q;
    arg_cmd_d  = arg_cmd_q;
    timer_d    = timer_q;
    rx_cmd_d   = rx_cmd_q;
    rx_arg_d   = rx_arg_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    case (rx_state_q)
      R_CMD: begin
        if (bus.i_BYTE_RX_VALID && !rx_blocked) begin
          if ((bus.i_BYTE_RX == CMD_READ) || (bus.i_BYTE_RX == CMD_STOP)) begin
            rx_cmd_d   = bus.i_BYTE_RX;
            rx_arg_d   = 8'h00;
            rx_valid_d = 1'b1;
          end else if ((bus.i_BYTE_RX == CMD_ADDR) || (bus.i_BYTE_RX == CMD_MODE)) begin
            arg_cmd_d  = bus.i_BYTE_RX;
            timer_d    = '0;
            rx_state_d = R_ARG;
          end else begin
            rx_err_d = 1'b1;
          end
        end
      end
      R_ARG: begin
        // An argument arriving on the timeout edge still completes the command.
        if (bus.i_BYTE_RX_VALID) begin
          rx_cmd_d   = arg_cmd_q;
          rx_arg_d   = bus.i_BYTE_RX;
          rx_valid_d = 1'b1;
          rx_state_d = R_CMD;
        end else if (timer_q == TMR_W'(RX_TIMEOUT - 1)) begin
          rx_err_d   = 1'b1;
          rx_state_d = R_CMD;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: rx_state_d = R_CMD;
    endcase
  end

  // RX state register; parsed command/argument hold between pulses.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      rx_state_q <= R_CMD;
      arg_cmd_q  <= 8'h00;
      timer_q    <= '0;
      rx_cmd_q   <= 8'h00;
      rx_arg_q   <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      arg_cmd_q  <= arg_cmd_d;
      timer_q    <= timer_d;
      rx_cmd_q   <= rx_cmd_d;
      rx_arg_q   <= rx_arg_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

endmodule
